// File: rtl/alert_sequencer.sv
// alert_sequencer: latches debounced button events, grants them by priority and drives a state code plus beep bursts.
// Optional feature macro: ERR_REPEAT_EN (an err burst re-runs while err is still held).
module alert_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int BEEP_TICKS = 100,
  parameter int GAP_TICKS  = 100,
  parameter int HOLD_TICKS = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       err,
  input  logic       off,
  input  logic       on,
  input  logic       open,
  input  logic       sound,
  output logic [2:0] state,
  output logic       buzzer,
  output logic       busy,
  output logic [3:0] pending
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int M1   = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
  localparam int MAXT = (M1 > HOLD_TICKS) ? M1 : HOLD_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  typedef enum logic [1:0] {IDLE, BEEP, GAP, HOLD} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [TW-1:0] tick_q;
  logic [3:0]    hist_q;
  logic [3:0]    pend_q, pend_d;
  logic [2:0]    code_q, code_d;
  logic [1:0]    beeps_q, beeps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          buzz_q;

  logic [3:0]    req, rise, grant;
  logic [2:0]    g_code;
  logic [1:0]    g_beeps;
  logic [CW-1:0] lim;
  logic          tick, ph_end, start, rpt, rpt_ok;

  assign req  = {open, on, off, err};
  assign rise = req & ~hist_q;
  assign tick = (tick_q == TW'(TICK_DIV - 1));

`ifdef ERR_REPEAT_EN
  assign rpt_ok = err && (code_q == 3'd1);
`else
  assign rpt_ok = 1'b0;
`endif

  // fixed priority err > off > on > open
  always_comb begin
    grant   = 4'b0000;
    g_code  = 3'd0;
    g_beeps = 2'd0;
    if (pend_q[0]) begin
      grant = 4'b0001; g_code = 3'd1; g_beeps = 2'd3;
    end else if (pend_q[1]) begin
      grant = 4'b0010; g_code = 3'd2; g_beeps = 2'd1;
    end else if (pend_q[2]) begin
      grant = 4'b0100; g_code = 3'd3; g_beeps = 2'd1;
    end else if (pend_q[3]) begin
      grant = 4'b1000; g_code = 3'd4; g_beeps = 2'd2;
    end
  end

  always_comb begin
    lim = CW'(HOLD_TICKS);
    if (fsm_q == BEEP) lim = CW'(BEEP_TICKS);
    else if (fsm_q == GAP) lim = CW'(GAP_TICKS);
  end

  assign ph_end = tick && (cnt_q == lim - CW'(1));

  always_comb begin
    fsm_d   = fsm_q;
    code_d  = code_q;
    beeps_d = beeps_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | rise;
    start   = 1'b0;
    rpt     = 1'b0;
    if (tick && cnt_q != CW'(MAXT)) cnt_d = cnt_q + CW'(1);
    unique case (fsm_q)
      IDLE: begin
        cnt_d = '0;
        start = |pend_q;
      end
      BEEP: if (ph_end) begin
        beeps_d = beeps_q - 2'd1;
        cnt_d   = '0;
        fsm_d   = (beeps_q > 2'd1) ? GAP : HOLD;
      end
      GAP: if (ph_end) begin
        cnt_d = '0;
        fsm_d = BEEP;
      end
      HOLD: if (ph_end) begin
        if (rpt_ok) rpt = 1'b1;
        else if (|pend_q) start = 1'b1;
        else begin
          fsm_d  = IDLE;
          code_d = 3'd0;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
    // err aborts any other sequence; the aborted request is not re-queued
    if (fsm_q != IDLE && code_q != 3'd1 && pend_q[0]) start = 1'b1;
    if (start) begin
      fsm_d   = BEEP;
      code_d  = g_code;
      beeps_d = g_beeps;
      cnt_d   = '0;
      pend_d  = (pend_q | rise) & ~grant;
    end else if (rpt) begin
      fsm_d   = BEEP;
      code_d  = 3'd1;
      beeps_d = 2'd3;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q  <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      fsm_q   <= IDLE;
      code_q  <= '0;
      beeps_q <= '0;
      cnt_q   <= '0;
      buzz_q  <= 1'b0;
    end else begin
      tick_q  <= tick ? '0 : tick_q + TW'(1);
      hist_q  <= req;
      pend_q  <= pend_d;
      fsm_q   <= fsm_d;
      code_q  <= code_d;
      beeps_q <= beeps_d;
      cnt_q   <= cnt_d;
      buzz_q  <= (fsm_d == BEEP) | sound;
    end
  end

  assign state   = code_q;
  assign buzzer  = buzz_q;
  assign busy    = (fsm_q != IDLE);
  assign pending = pend_q;

endmodule

// File: tb/tb_alert_sequencer.sv
// tb_alert_sequencer: directed vectors and corner sequences for alert_sequencer
// (TICK_DIV=4, BEEP_TICKS=2, GAP_TICKS=1, HOLD_TICKS=3).
module tb_alert_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       err, off, on, open, sound;
  logic [2:0] state;
  logic       buzzer, busy;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  alert_sequencer #(
    .TICK_DIV(4), .BEEP_TICKS(2), .GAP_TICKS(1), .HOLD_TICKS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .err(err), .off(off), .on(on), .open(open), .sound(sound),
    .state(state), .buzzer(buzzer), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [2:0] c1;
    logic [2:0] c2;
    int         beeps;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    err = r[0]; off = r[1]; on = r[2]; open = r[3];
  endtask

  // beep windows must last 5..8 cycles with these parameters
  task automatic run_idle(output int nb, output logic [2:0] c2,
                          output bit len_ok, output bit glitch, output bit to);
    logic [2:0] cur;
    logic       pb;
    int         len;
    cur = state; pb = buzzer;
    len = buzzer ? 1 : 0;
    nb = buzzer ? 1 : 0;
    c2 = 3'd0; len_ok = 1'b1; glitch = 1'b0; to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (buzzer && !pb) begin nb++; len = 1; end
      else if (buzzer) len++;
      else if (pb && (len < 5 || len > 8)) len_ok = 1'b0;
      pb = buzzer;
      if (busy && state == 3'd0) glitch = 1'b1;
      if (busy && state != 3'd0 && state != cur) begin
        if (c2 == 3'd0) c2 = state;
        cur = state;
      end
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_gap(input string name);
    bit seen;
    logic pb;
    seen = 1'b0;
    pb = buzzer;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pb && !buzzer && busy && state == 3'd4) begin seen = 1'b1; break; end
      pb = buzzer;
    end
    chk(name, seen, 1);
  endtask

  int nb;
  logic [2:0] c2;
  bit lok, gl, to;

  initial begin
    vt[0] = '{4'b1000, 3'd4, 3'd0, 2};
    vt[1] = '{4'b0001, 3'd1, 3'd0, 3};
    vt[2] = '{4'b0010, 3'd2, 3'd0, 1};
    vt[3] = '{4'b0100, 3'd3, 3'd0, 1};
    vt[4] = '{4'b1001, 3'd1, 3'd4, 5};
    vt[5] = '{4'b0110, 3'd2, 3'd3, 2};

    // reset with err held high
    reset_n = 1'b0; sound = 1'b0;
    set_req(4'b0001);
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();
    chk("rel_pending", pending, 1);
    chk("rel_state0", state, 0);
    step();
    chk("rel_state", state, 1);
    chk("rel_busy", busy, 1);
    chk("rel_pend_clr", pending, 0);
    chk("rel_buzzer", buzzer, 1);
    set_req(4'b0000);
    run_idle(nb, c2, lok, gl, to);
    chk("rel_timeout", to, 0);
    chk("rel_beeps", nb, 3);
    chk("rel_len", lok, 1);

    // single and simultaneous requests from idle
    for (int k = 0; k < 6; k++) begin
      step();
      set_req(vt[k].req);
      step();
      chk($sformatf("v%0d_pending", k), pending, vt[k].req);
      set_req(4'b0000);
      step();
      chk($sformatf("v%0d_state", k), state, vt[k].c1);
      chk($sformatf("v%0d_busy", k), busy, 1);
      run_idle(nb, c2, lok, gl, to);
      chk($sformatf("v%0d_timeout", k), to, 0);
      chk($sformatf("v%0d_beeps", k), nb, vt[k].beeps);
      chk($sformatf("v%0d_next", k), c2, vt[k].c2);
      chk($sformatf("v%0d_len", k), lok, 1);
      chk($sformatf("v%0d_noidle", k), gl, 0);
      chk($sformatf("v%0d_end_state", k), state, 0);
      chk($sformatf("v%0d_end_pend", k), pending, 0);
    end

    // err preempts open during GAP
    set_req(4'b1000);
    step();
    set_req(4'b0000);
    step();
    chk("pre_open", state, 4);
    wait_gap("pre_gap_seen");
    err = 1'b1;
    step();
    err = 1'b0;
    chk("pre_pend", pending, 1);
    step();
    chk("pre_state", state, 1);
    run_idle(nb, c2, lok, gl, to);
    chk("pre_timeout", to, 0);
    chk("pre_beeps", nb, 3);
    chk("pre_replay", c2, 0);
    chk("pre_end_pend", pending, 0);

    // manual buzzer
    sound = 1'b1;
    step();
    chk("snd_buzzer", buzzer, 1);
    chk("snd_state", state, 0);
    chk("snd_busy", busy, 0);
    sound = 1'b0;
    step();
    chk("snd_off", buzzer, 0);
    set_req(4'b1000);
    step();
    set_req(4'b0000);
    step();
    wait_gap("snd_gap_seen");
    sound = 1'b1;
    step();
    chk("snd_gap_buzzer", buzzer, 1);
    chk("snd_gap_state", state, 4);
    sound = 1'b0;
    run_idle(nb, c2, lok, gl, to);
    chk("snd_timeout", to, 0);

    // err held high
    err = 1'b1;
    step();
    step();
    chk("hold_state", state, 1);
    begin
      logic pb;
      bit idle;
      pb = buzzer;
      nb = buzzer ? 1 : 0;
      idle = 1'b0;
      for (int i = 0; i < 600; i++) begin
        step();
        if (buzzer && !pb) nb++;
        pb = buzzer;
        if (nb == 4) err = 1'b0;
        if (!busy) begin idle = 1'b1; break; end
      end
      chk("hold_idle", idle, 1);
`ifdef ERR_REPEAT_EN
      chk("hold_beeps", nb, 6);
`else
      chk("hold_beeps", nb, 3);
`endif
      chk("hold_pend", pending, 0);
      err = 1'b0;
    end

    // asynchronous reset mid-sequence
    step();
    set_req(4'b0010);
    step();
    set_req(4'b0000);
    repeat (3) step();
    chk("mid_busy_pre", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_state", state, 0);
    chk("mid_busy", busy, 0);
    chk("mid_buzzer", buzzer, 0);
    chk("mid_pending", pending, 0);
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
